stack_rpn_sequencer: RTL and testbench
======================================

Name: stack_rpn_sequencer

Overview:
- Upstream command sequencer for the 5-entry, 4-bit stack unit (COMMAND 00 nop / 01 push / 10 pop / 11 get, INDEX, I_DATA, O_DATA).
- Accepts a stream of RPN tokens (operands and operators) over a valid/ready handshake and drives the stack's command port.
- Consumes the stack's O_DATA to perform 4-bit ALU operations and pushes the results back.
- Tracks stack occupancy itself, because the stack silently wraps; reports underflow and overflow.

Parameters:
- WIDTH, 4, data width of stack entries and tokens.
- DEPTH, 5, stack capacity; the COUNT saturation point.
- IDXW, 3, width of the stack INDEX port.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous reset, active-low.
- TOK_VALID  in  1  a token is presented.
- TOK_READY  out  1  the sequencer accepts a token this cycle.
- TOK_KIND  in  1  0 = operand, 1 = operator.
- TOK_DATA  in  WIDTH  operand value, or operator code.
- S_COMMAND  out  2  to stack COMMAND.
- S_INDEX  out  IDXW  to stack INDEX.
- S_DATA  out  WIDTH  to stack I_DATA.
- S_Q  in  WIDTH  from stack O_DATA.
- STK_RESET  out  1  active-high reset to the stack unit.
- COUNT  out  3  tracked occupancy, 0..DEPTH.
- RESULT  out  WIDTH  last ALU or DUP value pushed.
- RESULT_VALID  out  1  one-cycle pulse, coincident with the result push.
- ERR_UNDER  out  1  sticky underflow flag.
- ERR_OVER  out  1  sticky overflow flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are CLK and RESET_N.
- Reset values: S_COMMAND=00, S_INDEX=0, S_DATA=0, STK_RESET=1, COUNT=0, RESULT=0, RESULT_VALID=0, ERR_*=0, state=IDLE, TOK_READY=0.
- Reset release: STK_RESET drops at the first CLK edge after RESET_N rises.
- RESET_N assertion mid-sequence aborts the sequence immediately.
- All stack-facing outputs are registered. The stack acts on the command at the following edge.
- S_Q is valid in the cycle after a GET has been issued.
- TOK_READY=1 only in IDLE. A token is accepted on an edge where TOK_VALID and TOK_READY are both high.
- In all non-issuing states: S_COMMAND=00 and S_INDEX=0.
- Operator codes; A = top (index 0), B = index 1:
  - 0000 ADD: B+A
  - 0001 SUB: B−A
  - 0010 AND
  - 0011 XOR
  - 0100 DUP
  - 0101 DROP
  - 1111 CLEAR
  - any other code: consumed as a NOP, no error, stays in IDLE.
- Arithmetic: modulo 2^WIDTH; no carry or borrow out.
- Operand path: IDLE → PUSH, driving 01 with S_DATA=operand. Then back to IDLE; 2 cycles per operand.
- Binary operator path, when COUNT≥2:
  - IDLE → GET_A: 11, idx 0.
  - → GET_B: 11, idx 1; capture A from S_Q.
  - → CAP_B: 00; capture B.
  - → POP1: 10.
  - → POP2: 10.
  - → PUSH_R: 01, S_DATA=result; RESULT updated, RESULT_VALID=1.
  - → IDLE.
  - Net COUNT change −1; 7 cycles from accept to ready.
- DUP path, when COUNT≥1: GET_A → CAP_A → PUSH_R with value A; COUNT+1.
- DROP path, when COUNT≥1: POP1 → IDLE; COUNT−1.
- CLEAR: STK_RESET=1 for one cycle, COUNT=0, ERR_UNDER=ERR_OVER=0.
- Underflow (binary op with COUNT<2, or DUP/DROP with COUNT=0):
  - token consumed; no stack command issued; ERR_UNDER set; COUNT unchanged.
  - state stays IDLE, so the next token is accepted on the next edge.
- Overflow (push or DUP with COUNT=DEPTH):
  - push still issued, and the stack overwrites its oldest entry.
  - ERR_OVER set; COUNT stays DEPTH.
- A binary-op push never overflows, because two entries were popped first.
- ERR flags clear only on reset or CLEAR.

Decomposition:
- Package stack_rpn_pkg holds:
  - stack command constants: CMD_NOP, CMD_PUSH, CMD_POP, CMD_GET;
  - the operator-code enum;
  - the FSM state enum.
- One sub-module, stack_rpn_alu: combinational, takes op, A and B, returns the result.
- The FSM, occupancy counter and flags live in the top level.

Test Plan:
- Reset → STK_RESET=1 and TOK_READY=0 during reset. After release: COUNT=0, S_COMMAND=00.
- Push 0011, 0101, then ADD → stack commands 01, 01, 11/idx0, 11/idx1, 00, 10, 10, 01 with data 1000. RESULT=1000, one RESULT_VALID pulse, COUNT=1.
- Push 0010, 0101, then SUB → RESULT=1101 (2−5 mod 16). Push 1111, 0001, then ADD → 0000.
- ADD with COUNT=1 → no non-NOP command, ERR_UNDER=1, COUNT=1, TOK_READY high on the next cycle.
- Six operands pushed → sixth push is issued, ERR_OVER=1, COUNT=5. Then CLEAR → STK_RESET pulse, COUNT=0, both flags 0.
- Push 1001, DUP, XOR → RESULT=0000, COUNT=1. TOK_VALID held low for 3 cycles → S_COMMAND stays 00.

Source files
------------

// File: rtl/stack_rpn_pkg.sv
// Shared constants and types for the RPN command sequencer that fronts the
// 5-entry, 4-bit stack unit.
package stack_rpn_pkg;

    localparam int WIDTH = 4;
    localparam int DEPTH = 5;
    localparam int IDXW  = 3;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;
    localparam logic [1:0] CMD_GET  = 2'b11;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_DUP   = 4'b0100,
        OP_DROP  = 4'b0101,
        OP_CLEAR = 4'b1111
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PUSH,
        ST_GET_A,
        ST_GET_B,
        ST_CAP_A,
        ST_CAP_B,
        ST_POP1,
        ST_POP2,
        ST_PUSH_R,
        ST_CLEAR
    } state_e;

    function automatic logic is_binary(input logic [3:0] code);
        return (code == OP_ADD) || (code == OP_SUB) ||
               (code == OP_AND) || (code == OP_XOR);
    endfunction

endpackage

// File: rtl/stack_rpn_alu.sv
// Combinational 4-bit ALU for the RPN sequencer; A is the old top of stack,
// B the entry below it. Results wrap modulo 2^WIDTH.
module stack_rpn_alu
    import stack_rpn_pkg::*;
(
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = b + a;
            OP_SUB:  y = b - a;
            OP_AND:  y = b & a;
            OP_XOR:  y = b ^ a;
            OP_DUP:  y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/stack_rpn_sequencer.sv
// RPN token sequencer: turns operand/operator tokens into stack commands,
// shadows stack occupancy and flags underflow/overflow.
module stack_rpn_sequencer
    import stack_rpn_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             TOK_VALID,
    output logic             TOK_READY,
    input  logic             TOK_KIND,
    input  logic [WIDTH-1:0] TOK_DATA,
    output logic [1:0]       S_COMMAND,
    output logic [IDXW-1:0]  S_INDEX,
    output logic [WIDTH-1:0] S_DATA,
    input  logic [WIDTH-1:0] S_Q,
    output logic             STK_RESET,
    output logic [2:0]       COUNT,
    output logic [WIDTH-1:0] RESULT,
    output logic             RESULT_VALID,
    output logic             ERR_UNDER,
    output logic             ERR_OVER
);

    localparam logic [2:0] FULL = 3'(DEPTH);

    state_e           state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             stk_reset_q, stk_reset_d;
    logic [2:0]       count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             err_under_q, err_under_d;
    logic             err_over_q, err_over_d;
    logic             tok_ready_q, tok_ready_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] alu_y;
    logic             accept;

    stack_rpn_alu u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

    assign accept = TOK_VALID && tok_ready_q;

    // Every stack-facing output is computed for the state being entered, so the
    // registered command lines up with the state that owns it.
    always_comb begin
        state_d        = state_q;
        cmd_d          = CMD_NOP;
        idx_d          = '0;
        data_d         = '0;
        stk_reset_d    = 1'b0;
        count_d        = count_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        err_under_d    = err_under_q;
        err_over_d     = err_over_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = TOK_DATA;
                    if (!TOK_KIND) begin
                        state_d = ST_PUSH;
                        cmd_d   = CMD_PUSH;
                        data_d  = TOK_DATA;
                        if (count_q == FULL) err_over_d = 1'b1;
                        else                 count_d    = count_q + 3'd1;
                    end else if (is_binary(TOK_DATA)) begin
                        if (count_q >= 3'd2) begin
                            state_d = ST_GET_A;
                            cmd_d   = CMD_GET;
                            count_d = count_q - 3'd1;
                        end else begin
                            err_under_d = 1'b1;
                        end
                    end else if (TOK_DATA == OP_DUP) begin
                        if (count_q != 3'd0) begin
                            state_d = ST_GET_A;
                            cmd_d   = CMD_GET;
                            if (count_q == FULL) err_over_d = 1'b1;
                            else                 count_d    = count_q + 3'd1;
                        end else begin
                            err_under_d = 1'b1;
                        end
                    end else if (TOK_DATA == OP_DROP) begin
                        if (count_q != 3'd0) begin
                            state_d = ST_POP1;
                            cmd_d   = CMD_POP;
                            count_d = count_q - 3'd1;
                        end else begin
                            err_under_d = 1'b1;
                        end
                    end else if (TOK_DATA == OP_CLEAR) begin
                        state_d     = ST_CLEAR;
                        stk_reset_d = 1'b1;
                        count_d     = '0;
                        err_under_d = 1'b0;
                        err_over_d  = 1'b0;
                    end
                end
            end
            ST_GET_A: begin
                if (op_q == OP_DUP) begin
                    state_d = ST_CAP_A;
                end else begin
                    state_d = ST_GET_B;
                    cmd_d   = CMD_GET;
                    idx_d   = IDXW'(1);
                end
            end
            ST_GET_B: begin
                a_d     = S_Q;
                state_d = ST_CAP_B;
            end
            ST_CAP_A: begin
                a_d            = S_Q;
                state_d        = ST_PUSH_R;
                cmd_d          = CMD_PUSH;
                data_d         = S_Q;
                result_d       = S_Q;
                result_valid_d = 1'b1;
            end
            ST_CAP_B: begin
                b_d     = S_Q;
                state_d = ST_POP1;
                cmd_d   = CMD_POP;
            end
            ST_POP1: begin
                if (op_q == OP_DROP) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_POP2;
                    cmd_d   = CMD_POP;
                end
            end
            ST_POP2: begin
                state_d        = ST_PUSH_R;
                cmd_d          = CMD_PUSH;
                data_d         = alu_y;
                result_d       = alu_y;
                result_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        tok_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= ST_IDLE;
            cmd_q          <= CMD_NOP;
            idx_q          <= '0;
            data_q         <= '0;
            stk_reset_q    <= 1'b1;
            count_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_under_q    <= 1'b0;
            err_over_q     <= 1'b0;
            tok_ready_q    <= 1'b0;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            idx_q          <= idx_d;
            data_q         <= data_d;
            stk_reset_q    <= stk_reset_d;
            count_q        <= count_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_under_q    <= err_under_d;
            err_over_q     <= err_over_d;
            tok_ready_q    <= tok_ready_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
        end
    end

    assign TOK_READY    = tok_ready_q;
    assign S_COMMAND    = cmd_q;
    assign S_INDEX      = idx_q;
    assign S_DATA       = data_q;
    assign STK_RESET    = stk_reset_q;
    assign COUNT        = count_q;
    assign RESULT       = result_q;
    assign RESULT_VALID = result_valid_q;
    assign ERR_UNDER    = err_under_q;
    assign ERR_OVER     = err_over_q;

endmodule

// File: tb/tb_stack_rpn_sequencer.sv
// Directed bench for stack_rpn_sequencer, with a behavioural 5-entry stack
// answering the sequencer's commands.
module tb_stack_rpn_sequencer;
    import stack_rpn_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tok_valid = 1'b0;
    logic       tok_ready;
    logic       tok_kind = 1'b0;
    logic [3:0] tok_data = 4'd0;
    logic [1:0] s_command;
    logic [2:0] s_index;
    logic [3:0] s_data;
    logic [3:0] s_q;
    logic       stk_reset;
    logic [2:0] count;
    logic [3:0] result;
    logic       result_valid;
    logic       err_under;
    logic       err_over;

    int         checks = 0;
    int         errors = 0;
    int         pulse_count;
    int         wait_cycles;
    logic [3:0] pulse_data;
    logic [3:0] mem [0:4];

    stack_rpn_sequencer dut (
        .CLK          (clk),
        .RESET_N      (rst_n),
        .TOK_VALID    (tok_valid),
        .TOK_READY    (tok_ready),
        .TOK_KIND     (tok_kind),
        .TOK_DATA     (tok_data),
        .S_COMMAND    (s_command),
        .S_INDEX      (s_index),
        .S_DATA       (s_data),
        .S_Q          (s_q),
        .STK_RESET    (stk_reset),
        .COUNT        (count),
        .RESULT       (result),
        .RESULT_VALID (result_valid),
        .ERR_UNDER    (err_under),
        .ERR_OVER     (err_over)
    );

    always #5 clk = ~clk;

    // Stack unit: push shifts down and loses the oldest entry, pop shifts up,
    // get presents the addressed entry on s_q in the following cycle.
    always @(posedge clk) begin
        if (stk_reset) begin
            for (int i = 0; i < 5; i++) mem[i] <= 4'd0;
            s_q <= 4'd0;
        end else begin
            case (s_command)
                2'b01: begin
                    mem[0] <= s_data;
                    for (int i = 1; i < 5; i++) mem[i] <= mem[i-1];
                end
                2'b10: begin
                    for (int i = 0; i < 4; i++) mem[i] <= mem[i+1];
                    mem[4] <= 4'd0;
                end
                2'b11: s_q <= (s_index < 3'd5) ? mem[s_index] : 4'd0;
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one token and returns one tick after the edge that accepted it.
    task automatic applyStimulus(input logic kind, input logic [3:0] data);
        logic accepted;
        int   n;
        accepted  = 1'b0;
        n         = 0;
        tok_valid = 1'b1;
        tok_kind  = kind;
        tok_data  = data;
        while (!accepted && n < 30) begin
            accepted = tok_ready;
            step();
            n++;
        end
        tok_valid = 1'b0;
        tok_kind  = 1'b0;
        tok_data  = 4'd0;
        checkOutput("token accepted", 8'(accepted), 8'd1);
    endtask

    task automatic waitReady();
        pulse_count = 0;
        wait_cycles = 0;
        while (!tok_ready && wait_cycles < 40) begin
            step();
            wait_cycles++;
            if (result_valid) begin
                pulse_count++;
                pulse_data = result;
            end
        end
        checkOutput("ready reached", 8'(tok_ready), 8'd1);
    endtask

    initial begin
        // Reset held
        #12;
        checkOutput("reset stk_reset", 8'(stk_reset), 8'd1);
        checkOutput("reset tok_ready", 8'(tok_ready), 8'd0);
        checkOutput("reset count", 8'(count), 8'd0);
        checkOutput("reset command", 8'(s_command), 8'd0);
        checkOutput("reset result_valid", 8'(result_valid), 8'd0);
        #10;
        rst_n = 1'b1;
        step();
        checkOutput("release stk_reset", 8'(stk_reset), 8'd0);
        checkOutput("release tok_ready", 8'(tok_ready), 8'd1);
        checkOutput("release count", 8'(count), 8'd0);
        checkOutput("release command", 8'(s_command), 8'd0);

        // 3 + 5, command by command
        applyStimulus(1'b0, 4'b0011);
        checkOutput("push3 cmd", 8'(s_command), 8'd1);
        checkOutput("push3 data", 8'(s_data), 8'd3);
        checkOutput("push3 count", 8'(count), 8'd1);
        applyStimulus(1'b0, 4'b0101);
        checkOutput("push5 cmd", 8'(s_command), 8'd1);
        checkOutput("push5 data", 8'(s_data), 8'd5);
        checkOutput("push5 count", 8'(count), 8'd2);
        applyStimulus(1'b1, OP_ADD);
        checkOutput("add get_a cmd", 8'(s_command), 8'd3);
        checkOutput("add get_a idx", 8'(s_index), 8'd0);
        step();
        checkOutput("add get_b cmd", 8'(s_command), 8'd3);
        checkOutput("add get_b idx", 8'(s_index), 8'd1);
        step();
        checkOutput("add cap_b cmd", 8'(s_command), 8'd0);
        step();
        checkOutput("add pop1 cmd", 8'(s_command), 8'd2);
        step();
        checkOutput("add pop2 cmd", 8'(s_command), 8'd2);
        step();
        checkOutput("add push_r cmd", 8'(s_command), 8'd1);
        checkOutput("add push_r data", 8'(s_data), 8'h8);
        checkOutput("add result", 8'(result), 8'h8);
        checkOutput("add result_valid", 8'(result_valid), 8'd1);
        step();
        checkOutput("add pulse ends", 8'(result_valid), 8'd0);
        checkOutput("add idle cmd", 8'(s_command), 8'd0);
        checkOutput("add ready", 8'(tok_ready), 8'd1);
        checkOutput("add count", 8'(count), 8'd1);

        // 2 - 5 wraps to 13; ready returns six edges after the accepting edge
        applyStimulus(1'b0, 4'b0010);
        applyStimulus(1'b0, 4'b0101);
        applyStimulus(1'b1, OP_SUB);
        waitReady();
        checkOutput("sub latency", 8'(wait_cycles), 8'd6);
        checkOutput("sub pulses", 8'(pulse_count), 8'd1);
        checkOutput("sub pushed", 8'(pulse_data), 8'hD);
        checkOutput("sub result", 8'(result), 8'hD);
        checkOutput("sub count", 8'(count), 8'd2);

        // 15 + 1 wraps to 0
        applyStimulus(1'b0, 4'b1111);
        applyStimulus(1'b0, 4'b0001);
        applyStimulus(1'b1, OP_ADD);
        waitReady();
        checkOutput("wrap add pulses", 8'(pulse_count), 8'd1);
        checkOutput("wrap add result", 8'(result), 8'h0);
        checkOutput("wrap add count", 8'(count), 8'd3);

        // Unassigned operator code is a silent NOP
        applyStimulus(1'b1, 4'b0111);
        checkOutput("nop ready", 8'(tok_ready), 8'd1);
        checkOutput("nop cmd", 8'(s_command), 8'd0);
        checkOutput("nop count", 8'(count), 8'd3);
        checkOutput("nop err_under", 8'(err_under), 8'd0);

        // Two drops leave a single entry
        applyStimulus(1'b1, OP_DROP);
        checkOutput("drop cmd", 8'(s_command), 8'd2);
        checkOutput("drop count", 8'(count), 8'd2);
        step();
        checkOutput("drop ready", 8'(tok_ready), 8'd1);
        applyStimulus(1'b1, OP_DROP);
        waitReady();
        checkOutput("drop2 count", 8'(count), 8'd1);

        // Binary op on one entry underflows
        applyStimulus(1'b1, OP_ADD);
        checkOutput("under cmd", 8'(s_command), 8'd0);
        checkOutput("under flag", 8'(err_under), 8'd1);
        checkOutput("under count", 8'(count), 8'd1);
        checkOutput("under ready", 8'(tok_ready), 8'd1);
        step();
        checkOutput("under cmd later", 8'(s_command), 8'd0);

        applyStimulus(1'b1, OP_CLEAR);
        checkOutput("clear stk_reset", 8'(stk_reset), 8'd1);
        checkOutput("clear count", 8'(count), 8'd0);
        checkOutput("clear err_under", 8'(err_under), 8'd0);
        step();
        checkOutput("clear pulse ends", 8'(stk_reset), 8'd0);

        // Six pushes into a five-deep stack
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 4'(i));
            checkOutput("fill cmd", 8'(s_command), 8'd1);
            checkOutput("fill data", 8'(s_data), 8'(i));
            checkOutput("fill count", 8'(count), (i > 5) ? 8'd5 : 8'(i));
            checkOutput("fill err_over", 8'(err_over), (i > 5) ? 8'd1 : 8'd0);
        end
        applyStimulus(1'b1, OP_CLEAR);
        checkOutput("clear2 stk_reset", 8'(stk_reset), 8'd1);
        checkOutput("clear2 count", 8'(count), 8'd0);
        checkOutput("clear2 err_over", 8'(err_over), 8'd0);
        checkOutput("clear2 err_under", 8'(err_under), 8'd0);
        waitReady();

        // 9 DUP XOR -> 0
        applyStimulus(1'b0, 4'b1001);
        applyStimulus(1'b1, OP_DUP);
        waitReady();
        checkOutput("dup pulses", 8'(pulse_count), 8'd1);
        checkOutput("dup pushed", 8'(pulse_data), 8'h9);
        checkOutput("dup count", 8'(count), 8'd2);
        applyStimulus(1'b1, OP_XOR);
        waitReady();
        checkOutput("xor pushed", 8'(pulse_data), 8'h0);
        checkOutput("xor result", 8'(result), 8'h0);
        checkOutput("xor count", 8'(count), 8'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("quiet cmd", 8'(s_command), 8'd0);
        end

        // Reset in the middle of an operation takes effect without a clock edge
        applyStimulus(1'b0, 4'b0001);
        applyStimulus(1'b0, 4'b0010);
        applyStimulus(1'b1, OP_ADD);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort cmd", 8'(s_command), 8'd0);
        checkOutput("abort stk_reset", 8'(stk_reset), 8'd1);
        checkOutput("abort count", 8'(count), 8'd0);
        checkOutput("abort ready", 8'(tok_ready), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
